phy_rx_demux: RTL

Receive-side lane demultiplexer for the PHY. It takes the single byte-wide serial stream produced by the transmit PHY, with lanes interleaved in the order 0,1,2,3 at the 4f rate, and locks onto frame alignment using comma bytes. It then rebuilds the four parallel 8-bit lanes with per-lane valids. The block runs entirely on the 4f clock and marks each completed 4-lane word with a one-cycle strobe, so downstream logic can re-time it to clk_f.

---
 rtl/phy_rx_demux.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/phy_rx_demux.sv
// Receive-side lane demultiplexer: locks onto comma alignment in the 4f byte stream
// and rebuilds four parallel 8-bit lanes with per-lane valids and a word strobe.
module phy_rx_demux #(
   parameter logic [7:0]  COMMA    = 8'hBC,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 16
) (
   input  logic       clk_4f,
   input  logic       reset_L,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic [7:0] data_out_0,
   output logic [7:0] data_out_1,
   output logic [7:0] data_out_2,
   output logic [7:0] data_out_3,
   output logic       valid_out_0,
   output logic       valid_out_1,
   output logic       valid_out_2,
   output logic       valid_out_3,
   output logic       word_valid,
   output logic       active
);

   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state_q,     state_d;
   logic [1:0]        lane_sel_q,  lane_sel_d;
   logic [CW-1:0]     comma_cnt_q, comma_cnt_d;
   logic [LW-1:0]     loss_cnt_q,  loss_cnt_d;
   logic [3:0][7:0]   stg_data_q,  stg_data_d;
   logic [3:0]        stg_valid_q, stg_valid_d;
   logic [3:0][7:0]   dout_q,      dout_d;
   logic [3:0]        vout_q,      vout_d;
   logic              word_valid_q, word_valid_d;
   logic              active_q,    active_d;

   logic is_comma;
   logic group_idle;

   assign is_comma   = valid_in && (data_in == COMMA);
   assign group_idle = (&stg_valid_q[2:0]) && (stg_data_q[0] == COMMA) &&
                       (stg_data_q[1] == COMMA) && (stg_data_q[2] == COMMA) && is_comma;

   // NOTE: every signal gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d      = state_q;
      lane_sel_d   = lane_sel_q;
      comma_cnt_d  = comma_cnt_q;
      loss_cnt_d   = loss_cnt_q;
      stg_data_d   = stg_data_q;
      stg_valid_d  = stg_valid_q;
      dout_d       = dout_q;
      vout_d       = vout_q;
      word_valid_d = 1'b0;
      active_d     = active_q;

      case (state_q)
         SEARCH: begin
            if (!is_comma) begin
               comma_cnt_d = '0;
            end else if (comma_cnt_q == CW'(LOCK_CNT - 1)) begin
               // The locking comma belongs to no word; the next byte is lane 0.
               state_d     = LOCKED;
               lane_sel_d  = 2'd0;
               active_d    = 1'b1;
               comma_cnt_d = '0;
               loss_cnt_d  = '0;
            end else begin
               comma_cnt_d = comma_cnt_q + CW'(1);
            end
         end

         LOCKED: begin
            stg_data_d[lane_sel_q]  = data_in;
            stg_valid_d[lane_sel_q] = valid_in;
            lane_sel_d              = lane_sel_q + 2'd1;

            if (valid_in) begin
               loss_cnt_d = '0;
            end else if (loss_cnt_q != LW'(LOSS_CNT)) begin
               loss_cnt_d = loss_cnt_q + LW'(1);
            end

            // Lock loss wins over a group completing on the same edge.
            if (!valid_in && (loss_cnt_q == LW'(LOSS_CNT - 1))) begin
               state_d     = SEARCH;
               active_d    = 1'b0;
               vout_d      = '0;
               comma_cnt_d = '0;
               loss_cnt_d  = '0;
               lane_sel_d  = 2'd0;
            end else if (lane_sel_q == 2'd3 && !group_idle) begin
               dout_d       = {data_in, stg_data_q[2], stg_data_q[1], stg_data_q[0]};
               vout_d       = {valid_in, stg_valid_q[2:0]};
               word_valid_d = 1'b1;
            end
         end

         default: state_d = SEARCH;
      endcase
   end

   // NOTE: the staging array is reset along with the control state so a word assembled right
   // after relock can never expose bytes left over from before reset.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         state_q      <= SEARCH;
         lane_sel_q   <= '0;
         comma_cnt_q  <= '0;
         loss_cnt_q   <= '0;
         stg_data_q   <= '0;
         stg_valid_q  <= '0;
         dout_q       <= '0;
         vout_q       <= '0;
         word_valid_q <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q      <= state_d;
         lane_sel_q   <= lane_sel_d;
         comma_cnt_q  <= comma_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
         stg_data_q   <= stg_data_d;
         stg_valid_q  <= stg_valid_d;
         dout_q       <= dout_d;
         vout_q       <= vout_d;
         word_valid_q <= word_valid_d;
         active_q     <= active_d;
      end
   end

   assign data_out_0  = dout_q[0];
   assign data_out_1  = dout_q[1];
   assign data_out_2  = dout_q[2];
   assign data_out_3  = dout_q[3];
   assign valid_out_0 = vout_q[0];
   assign valid_out_1 = vout_q[1];
   assign valid_out_2 = vout_q[2];
   assign valid_out_3 = vout_q[3];
   assign word_valid  = word_valid_q;
   assign active      = active_q;

endmodule
